aibcr3_dcc_sar_cal: RTL and testbench



---
 rtl/aibcr3_dcc_pkg.sv | 22 ++
 rtl/aibcr3_dcc_vote_cnt.sv | 47 ++++
 rtl/aibcr3_dcc_sar_cal.sv | 159 +++++++++++++++
 tb/tb_aibcr3_dcc_sar_cal.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/aibcr3_dcc_pkg.sv
// Shared types and defaults for the DCC successive-approximation calibration controller.
// Provides the FSM state encoding and the mid-scale code helper.
package aibcr3_dcc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } dcc_state_e;

  localparam int DEF_CODE_W     = 5;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_AVG_W      = 4;

  // Mid-scale trial code: MSB set, all lower bits clear.
  function automatic logic [31:0] mid_code(input int code_w);
    return 32'd1 << (code_w - 1);
  endfunction

endpackage

// File: rtl/aibcr3_dcc_vote_cnt.sv
// Comparator vote accumulator: counts window samples and ones, flags a strict majority.
// Both counters saturate so a stretched window can never wrap the vote.
module aibcr3_dcc_vote_cnt
  import aibcr3_dcc_pkg::*;
#(
  parameter int AVG_W = DEF_AVG_W
) (
  input  logic CK,
  input  logic RSTN,
  input  logic clr,
  input  logic smp_en,
  input  logic dn,
  output logic maj,
  output logic win_last
);

  localparam int CW = AVG_W + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] WIN_LAST = CW'((1 << AVG_W) - 1);
  localparam logic [CW-1:0] HALF     = CW'(1 << (AVG_W - 1));

  logic [CW-1:0] smp_cnt_r;
  logic [CW-1:0] one_cnt_r;

  // Sample and ones counters, cleared whenever a window is not in progress.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      smp_cnt_r <= {CW{1'b0}};
      one_cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      smp_cnt_r <= {CW{1'b0}};
      one_cnt_r <= {CW{1'b0}};
    end else if (smp_en) begin
      if (smp_cnt_r != CNT_MAX) begin
        smp_cnt_r <= smp_cnt_r + CNT_ONE;
      end
      if (dn && (one_cnt_r != CNT_MAX)) begin
        one_cnt_r <= one_cnt_r + CNT_ONE;
      end
    end
  end

  assign maj      = (one_cnt_r > HALF);
  assign win_last = smp_en && (smp_cnt_r == WIN_LAST);

endmodule

// File: rtl/aibcr3_dcc_sar_cal.sv
// DCC trim SAR calibration: MSB-first search with settle delay and majority-voted decisions.
// code_out is only ever a flop so the downstream code register sees a clean bus.
module aibcr3_dcc_sar_cal
  import aibcr3_dcc_pkg::*;
#(
  parameter int CODE_W     = DEF_CODE_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int AVG_W      = DEF_AVG_W
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              cal_en,
  input  logic              dn,
  input  logic              ovr_en,
  input  logic [CODE_W-1:0] ovr_code,
  output logic [CODE_W-1:0] code_out,
  output logic              cal_busy,
  output logic              cal_done
);

  localparam int PTR_W = $clog2(CODE_W);
  localparam int SC_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CODE_W-1:0] MID         = CODE_W'(mid_code(CODE_W));
  localparam logic [PTR_W-1:0]  PTR_TOP     = PTR_W'(CODE_W - 1);
  localparam logic [PTR_W-1:0]  PTR_ZERO    = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
  localparam logic [SC_W-1:0]   SC_ZERO     = {SC_W{1'b0}};
  localparam logic [SC_W-1:0]   SC_ONE      = SC_W'(1);
  localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE_CYC - 1);

  dcc_state_e        state_r;
  logic [CODE_W-1:0] code_r;
  logic [PTR_W-1:0]  bit_ptr_r;
  logic [SC_W-1:0]   set_cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              maj_s;
  logic              win_last_s;
  logic              smp_en_s;
  logic              vclr_s;

  // Votes accumulate only in SAMPLE; abort or override clears them on the same edge.
  assign smp_en_s = (state_r == ST_SAMPLE);
  assign vclr_s   = !smp_en_s || !cal_en || ovr_en;

  aibcr3_dcc_vote_cnt #(
    .AVG_W (AVG_W)
  ) u_vote (
    .CK       (CK),
    .RSTN     (RSTN),
    .clr      (vclr_s),
    .smp_en   (smp_en_s),
    .dn       (dn),
    .maj      (maj_s),
    .win_last (win_last_s)
  );

  // Calibration FSM with code register, bit pointer, settle counter and status flags.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_r   <= ST_IDLE;
      code_r    <= MID;
      bit_ptr_r <= PTR_ZERO;
      set_cnt_r <= SC_ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (ovr_en) begin
      state_r   <= ST_IDLE;
      code_r    <= ovr_code;
      bit_ptr_r <= PTR_ZERO;
      set_cnt_r <= SC_ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cal_en) begin
            state_r   <= ST_SETTLE;
            code_r    <= MID;
            bit_ptr_r <= PTR_TOP;
            set_cnt_r <= SC_ZERO;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        ST_SETTLE, ST_SAMPLE, ST_DECIDE: begin
          if (!cal_en) begin
            state_r   <= ST_IDLE;
            code_r    <= MID;
            bit_ptr_r <= PTR_ZERO;
            set_cnt_r <= SC_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
          end else begin
            case (state_r)
              ST_SETTLE: begin
                if (set_cnt_r == SETTLE_LAST) begin
                  set_cnt_r <= SC_ZERO;
                  state_r   <= ST_SAMPLE;
                end else begin
                  set_cnt_r <= set_cnt_r + SC_ONE;
                end
              end
              ST_SAMPLE: begin
                if (win_last_s) begin
                  state_r <= ST_DECIDE;
                end
              end
              ST_DECIDE: begin
                // Strict majority of "too high" votes clears the trial bit; ties keep it.
                if (maj_s) begin
                  code_r[bit_ptr_r] <= 1'b0;
                end
                if (bit_ptr_r == PTR_ZERO) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                end else begin
                  bit_ptr_r                   <= bit_ptr_r - PTR_ONE;
                  code_r[bit_ptr_r - PTR_ONE] <= 1'b1;
                  state_r                     <= ST_SETTLE;
                end
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_DONE: begin
          if (!cal_en) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end else begin
            done_r <= 1'b1;
          end
          busy_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          code_r    <= MID;
          bit_ptr_r <= PTR_ZERO;
          set_cnt_r <= SC_ZERO;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign code_out = code_r;
  assign cal_busy = busy_r;
  assign cal_done = done_r;

endmodule

// File: tb/tb_aibcr3_dcc_sar_cal.sv
// Directed self-checking bench for aibcr3_dcc_sar_cal with default parameters.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_aibcr3_dcc_sar_cal;

  logic       CK;
  logic       RSTN;
  logic       cal_en;
  logic       dn;
  logic       ovr_en;
  logic [4:0] ovr_code;
  logic [4:0] code_out;
  logic       cal_busy;
  logic       cal_done;

  int n_chk;
  int n_err;

  logic [4:0] exp_step [5] = '{5'b11000, 5'b11100, 5'b11110, 5'b11111, 5'b11111};

  aibcr3_dcc_sar_cal #(
    .CODE_W     (5),
    .SETTLE_CYC (8),
    .AVG_W      (4)
  ) dut (
    .CK       (CK),
    .RSTN     (RSTN),
    .cal_en   (cal_en),
    .dn       (dn),
    .ovr_en   (ovr_en),
    .ovr_code (ovr_code),
    .code_out (code_out),
    .cal_busy (cal_busy),
    .cal_done (cal_done)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // mode: 0 dn=0, 1 dn=1, 2 comparator code_out>13, 3 alternating (8/16), 4 nine of sixteen high
  task automatic run_cal(input int mode, input logic [4:0] exp_final);
    int j;
    cal_en = 1'b1;
    dn     = 1'b0;
    tick();
    chk("start_code", {27'd0, code_out}, 32'h10);
    chk("start_busy", {31'd0, cal_busy}, 32'd1);
    for (int k = 1; k <= 125; k++) begin
      j = (k - 1) % 25;
      case (mode)
        0:       dn = 1'b0;
        1:       dn = 1'b1;
        2:       dn = (code_out > 5'd13);
        3:       dn = j[0];
        4:       dn = (j >= 8) && (j <= 16);
        default: dn = 1'b0;
      endcase
      tick();
      if (k == 124) chk("done_early", {31'd0, cal_done}, 32'd0);
      if ((mode == 0) && (k % 25 == 0)) chk("step", {27'd0, code_out}, {27'd0, exp_step[k/25-1]});
    end
    chk("final_code", {27'd0, code_out}, {27'd0, exp_final});
    chk("final_done", {31'd0, cal_done}, 32'd1);
    chk("final_busy", {31'd0, cal_busy}, 32'd0);
  endtask

  task automatic drop_cal(input logic [4:0] exp_code);
    cal_en = 1'b0;
    dn     = 1'b0;
    tick();
    chk("idle_code", {27'd0, code_out}, {27'd0, exp_code});
    chk("idle_done", {31'd0, cal_done}, 32'd0);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    RSTN     = 1'b0;
    cal_en   = 1'b0;
    dn       = 1'b0;
    ovr_en   = 1'b0;
    ovr_code = 5'd0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      cal_en   = 1'($urandom_range(0, 1));
      dn       = 1'($urandom_range(0, 1));
      ovr_en   = 1'($urandom_range(0, 1));
      ovr_code = 5'($urandom_range(0, 31));
      tick();
      chk("rst_code", {27'd0, code_out}, 32'h10);
      chk("rst_busy", {31'd0, cal_busy}, 32'd0);
      chk("rst_done", {31'd0, cal_done}, 32'd0);
    end
    cal_en = 1'b0;
    ovr_en = 1'b0;
    dn     = 1'b0;
    RSTN   = 1'b1;
    tick();
    chk("idle_after_rst", {27'd0, code_out}, 32'h10);

    run_cal(0, 5'b11111);
    drop_cal(5'b11111);
    run_cal(2, 5'b01101);
    drop_cal(5'b01101);
    run_cal(1, 5'b00000);
    drop_cal(5'b00000);
    run_cal(3, 5'b11111);
    drop_cal(5'b11111);
    run_cal(4, 5'b00000);
    drop_cal(5'b00000);

    // Abort at cycle 40 then a full rerun
    cal_en = 1'b1;
    dn     = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    chk("pre_abort_code", {27'd0, code_out}, 32'h18);
    cal_en = 1'b0;
    tick();
    chk("abort_code", {27'd0, code_out}, 32'h10);
    chk("abort_busy", {31'd0, cal_busy}, 32'd0);
    chk("abort_done", {31'd0, cal_done}, 32'd0);
    run_cal(0, 5'b11111);
    drop_cal(5'b11111);

    // Asynchronous reset mid-SAMPLE
    cal_en = 1'b1;
    for (int k = 0; k < 41; k++) tick();
    chk("pre_rst_busy", {31'd0, cal_busy}, 32'd1);
    RSTN = 1'b0;
    #2;
    chk("midrst_code", {27'd0, code_out}, 32'h10);
    chk("midrst_busy", {31'd0, cal_busy}, 32'd0);
    chk("midrst_done", {31'd0, cal_done}, 32'd0);
    tick();
    cal_en = 1'b0;
    RSTN   = 1'b1;
    tick();

    // Override during calibration
    cal_en = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    ovr_en   = 1'b1;
    ovr_code = 5'b00111;
    tick();
    chk("ovr_code", {27'd0, code_out}, 32'h07);
    chk("ovr_busy", {31'd0, cal_busy}, 32'd0);
    chk("ovr_done", {31'd0, cal_done}, 32'd0);
    tick();
    chk("ovr_hold_idle", {31'd0, cal_busy}, 32'd0);
    ovr_en = 1'b0;
    cal_en = 1'b0;
    ovr_code = 5'b11010;
    tick();
    chk("ovr_release_code", {27'd0, code_out}, 32'h07);
    tick();
    chk("ovr_release_hold", {27'd0, code_out}, 32'h07);
    cal_en = 1'b1;
    tick();
    chk("restart_code", {27'd0, code_out}, 32'h10);
    chk("restart_busy", {31'd0, cal_busy}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
